// File: rtl/tl_ul_arb2.sv
// Two-client TileLink-UL arbiter: round-robin A-channel merge with a grant lock
// under backpressure, D routing by the widened source bit, per-client outstanding counts.
module tl_ul_arb2 #(
  parameter int SRC_W   = 2,
  parameter int ADDR_W  = 30,
  parameter int MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // client 0
  input  logic              c0_a_valid,
  output logic              c0_a_ready,
  input  logic [2:0]        c0_a_opcode,
  input  logic [2:0]        c0_a_param,
  input  logic [1:0]        c0_a_size,
  input  logic [SRC_W-1:0]  c0_a_source,
  input  logic [ADDR_W-1:0] c0_a_address,
  input  logic [3:0]        c0_a_mask,
  input  logic [31:0]       c0_a_data,
  output logic              c0_d_valid,
  input  logic              c0_d_ready,
  output logic [2:0]        c0_d_opcode,
  output logic [1:0]        c0_d_param,
  output logic [1:0]        c0_d_size,
  output logic [SRC_W-1:0]  c0_d_source,
  output logic              c0_d_sink,
  output logic              c0_d_denied,
  output logic [31:0]       c0_d_data,
  output logic              c0_d_corrupt,
  // client 1
  input  logic              c1_a_valid,
  output logic              c1_a_ready,
  input  logic [2:0]        c1_a_opcode,
  input  logic [2:0]        c1_a_param,
  input  logic [1:0]        c1_a_size,
  input  logic [SRC_W-1:0]  c1_a_source,
  input  logic [ADDR_W-1:0] c1_a_address,
  input  logic [3:0]        c1_a_mask,
  input  logic [31:0]       c1_a_data,
  output logic              c1_d_valid,
  input  logic              c1_d_ready,
  output logic [2:0]        c1_d_opcode,
  output logic [1:0]        c1_d_param,
  output logic [1:0]        c1_d_size,
  output logic [SRC_W-1:0]  c1_d_source,
  output logic              c1_d_sink,
  output logic              c1_d_denied,
  output logic [31:0]       c1_d_data,
  output logic              c1_d_corrupt,
  // manager A
  output logic              m_a_valid,
  input  logic              m_a_ready,
  output logic [2:0]        m_a_opcode,
  output logic [2:0]        m_a_param,
  output logic [1:0]        m_a_size,
  output logic [SRC_W:0]    m_a_source,
  output logic [ADDR_W-1:0] m_a_address,
  output logic [3:0]        m_a_mask,
  output logic [31:0]       m_a_data,
  // manager D
  input  logic              m_d_valid,
  output logic              m_d_ready,
  input  logic [2:0]        m_d_opcode,
  input  logic [1:0]        m_d_param,
  input  logic [1:0]        m_d_size,
  input  logic [SRC_W:0]    m_d_source,
  input  logic              m_d_sink,
  input  logic              m_d_denied,
  input  logic [31:0]       m_d_data,
  input  logic              m_d_corrupt,
  output logic              err_unexpected_d
);
  localparam int CNT_W = 4;

  logic [1:0] a_valid;
  logic [1:0] elig;
  logic [1:0] d_unexp;
  logic       win;
  logic       a_fire;
  logic       d_fire;
  logic       d_idx;
  logic       lock_q, lock_d;
  logic       lock_idx_q, lock_idx_d;
  logic       rr_q, rr_d;
  logic       err_q, err_d;

  assign a_valid = {c1_a_valid, c0_a_valid};
  assign d_idx   = m_d_source[SRC_W];

  // A held-off request keeps its grant so the manager sees a stable payload.
  always_comb begin
    if (lock_q)
      win = lock_idx_q;
    else if (&elig)
      win = rr_q;
    else
      win = elig[1];
  end

  assign m_a_valid   = lock_q ? elig[lock_idx_q] : |elig;
  assign a_fire      = m_a_valid & m_a_ready;
  assign c0_a_ready  = m_a_ready & m_a_valid & ~win;
  assign c1_a_ready  = m_a_ready & m_a_valid & win;

  assign m_a_opcode  = win ? c1_a_opcode  : c0_a_opcode;
  assign m_a_param   = win ? c1_a_param   : c0_a_param;
  assign m_a_size    = win ? c1_a_size    : c0_a_size;
  assign m_a_source  = {win, (win ? c1_a_source : c0_a_source)};
  assign m_a_address = win ? c1_a_address : c0_a_address;
  assign m_a_mask    = win ? c1_a_mask    : c0_a_mask;
  assign m_a_data    = win ? c1_a_data    : c0_a_data;

  assign c0_d_valid  = m_d_valid & ~d_idx;
  assign c1_d_valid  = m_d_valid & d_idx;
  assign m_d_ready   = d_idx ? c1_d_ready : c0_d_ready;
  assign d_fire      = m_d_valid & m_d_ready;

  assign c0_d_opcode  = m_d_opcode;
  assign c0_d_param   = m_d_param;
  assign c0_d_size    = m_d_size;
  assign c0_d_source  = m_d_source[SRC_W-1:0];
  assign c0_d_sink    = m_d_sink;
  assign c0_d_denied  = m_d_denied;
  assign c0_d_data    = m_d_data;
  assign c0_d_corrupt = m_d_corrupt;
  assign c1_d_opcode  = m_d_opcode;
  assign c1_d_param   = m_d_param;
  assign c1_d_size    = m_d_size;
  assign c1_d_source  = m_d_source[SRC_W-1:0];
  assign c1_d_sink    = m_d_sink;
  assign c1_d_denied  = m_d_denied;
  assign c1_d_data    = m_d_data;
  assign c1_d_corrupt = m_d_corrupt;

  // Per-client outstanding counter; eligibility looks only at the registered count.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_client
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             mine_a, mine_d, inc, dec;

      assign mine_a      = a_fire && (win == 1'(gi));
      assign mine_d      = d_fire && (d_idx == 1'(gi));
      assign inc         = mine_a && (cnt_q != CNT_W'(MAX_OUT));
      assign dec         = mine_d && (cnt_q != '0);
      assign d_unexp[gi] = mine_d && (cnt_q == '0);
      assign elig[gi]    = a_valid[gi] && (cnt_q < CNT_W'(MAX_OUT));

      always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec)
          cnt_d = cnt_q + 1'b1;
        else if (dec && !inc)
          cnt_d = cnt_q - 1'b1;
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          cnt_q <= '0;
        else
          cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign lock_d     = m_a_valid & ~m_a_ready;
  assign lock_idx_d = lock_d ? win : lock_idx_q;
  assign rr_d       = a_fire ? ~win : rr_q;
  assign err_d      = err_q | (|d_unexp);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
      rr_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
      err_q      <= err_d;
    end
  end

  assign err_unexpected_d = err_q;
endmodule

// File: tb/tb_tl_ul_arb2.sv
// Bench for tl_ul_arb2: directed scenarios then random traffic, all checked
// against a request-list model of the two clients and the manager.
module tb_tl_ul_arb2;
  localparam int SRC_W   = 2;
  localparam int ADDR_W  = 30;
  localparam int MAX_OUT = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic              ca_valid   [2];
  logic [2:0]        ca_opcode  [2];
  logic [2:0]        ca_param   [2];
  logic [1:0]        ca_size    [2];
  logic [SRC_W-1:0]  ca_source  [2];
  logic [ADDR_W-1:0] ca_address [2];
  logic [3:0]        ca_mask    [2];
  logic [31:0]       ca_data    [2];
  logic              cd_ready   [2];

  logic              c0_a_ready, c1_a_ready, c0_d_valid, c1_d_valid;
  logic [2:0]        c0_d_opcode, c1_d_opcode;
  logic [1:0]        c0_d_param, c1_d_param, c0_d_size, c1_d_size;
  logic [SRC_W-1:0]  c0_d_source, c1_d_source;
  logic              c0_d_sink, c1_d_sink, c0_d_denied, c1_d_denied;
  logic [31:0]       c0_d_data, c1_d_data;
  logic              c0_d_corrupt, c1_d_corrupt;

  logic              ma_ready;
  logic              m_a_valid;
  logic [2:0]        m_a_opcode, m_a_param;
  logic [1:0]        m_a_size;
  logic [SRC_W:0]    m_a_source;
  logic [ADDR_W-1:0] m_a_address;
  logic [3:0]        m_a_mask;
  logic [31:0]       m_a_data;

  logic              md_valid;
  logic [2:0]        md_opcode;
  logic [1:0]        md_param, md_size;
  logic [SRC_W:0]    md_source;
  logic              md_sink, md_denied, md_corrupt;
  logic [31:0]       md_data;
  logic              m_d_ready;
  logic              err_unexpected_d;

  tl_ul_arb2 #(.SRC_W(SRC_W), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .c0_a_valid(ca_valid[0]), .c0_a_ready(c0_a_ready), .c0_a_opcode(ca_opcode[0]),
    .c0_a_param(ca_param[0]), .c0_a_size(ca_size[0]), .c0_a_source(ca_source[0]),
    .c0_a_address(ca_address[0]), .c0_a_mask(ca_mask[0]), .c0_a_data(ca_data[0]),
    .c0_d_valid(c0_d_valid), .c0_d_ready(cd_ready[0]), .c0_d_opcode(c0_d_opcode),
    .c0_d_param(c0_d_param), .c0_d_size(c0_d_size), .c0_d_source(c0_d_source),
    .c0_d_sink(c0_d_sink), .c0_d_denied(c0_d_denied), .c0_d_data(c0_d_data),
    .c0_d_corrupt(c0_d_corrupt),
    .c1_a_valid(ca_valid[1]), .c1_a_ready(c1_a_ready), .c1_a_opcode(ca_opcode[1]),
    .c1_a_param(ca_param[1]), .c1_a_size(ca_size[1]), .c1_a_source(ca_source[1]),
    .c1_a_address(ca_address[1]), .c1_a_mask(ca_mask[1]), .c1_a_data(ca_data[1]),
    .c1_d_valid(c1_d_valid), .c1_d_ready(cd_ready[1]), .c1_d_opcode(c1_d_opcode),
    .c1_d_param(c1_d_param), .c1_d_size(c1_d_size), .c1_d_source(c1_d_source),
    .c1_d_sink(c1_d_sink), .c1_d_denied(c1_d_denied), .c1_d_data(c1_d_data),
    .c1_d_corrupt(c1_d_corrupt),
    .m_a_valid(m_a_valid), .m_a_ready(ma_ready), .m_a_opcode(m_a_opcode),
    .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
    .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
    .m_d_valid(md_valid), .m_d_ready(m_d_ready), .m_d_opcode(md_opcode),
    .m_d_param(md_param), .m_d_size(md_size), .m_d_source(md_source),
    .m_d_sink(md_sink), .m_d_denied(md_denied), .m_d_data(md_data),
    .m_d_corrupt(md_corrupt),
    .err_unexpected_d(err_unexpected_d)
  );

  // Reference model: outstanding counts, preferred client, held grant, and the
  // manager's list of requests still awaiting a response.
  int             exp_cnt [2];
  int             pref;
  bit             locked;
  int             owner;
  bit             exp_err;
  logic [SRC_W:0] mgr_q [$];
  bit             fired [2];
  int             checks = 0;
  int             errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int n, input bit v, input logic [SRC_W-1:0] src);
    ca_valid[n]   = v;
    ca_source[n]  = src;
    ca_opcode[n]  = 3'($urandom);
    ca_param[n]   = 3'($urandom);
    ca_size[n]    = 2'($urandom);
    ca_address[n] = ADDR_W'($urandom);
    ca_mask[n]    = 4'($urandom);
    ca_data[n]    = $urandom;
  endtask

  task automatic dresp(input bit v, input logic [SRC_W:0] src, input bit r0, input bit r1);
    md_valid   = v;
    md_source  = src;
    md_opcode  = 3'($urandom);
    md_param   = 2'($urandom);
    md_size    = 2'($urandom);
    md_sink    = 1'($urandom);
    md_denied  = 1'($urandom);
    md_corrupt = 1'($urandom);
    md_data    = $urandom;
    cd_ready[0] = r0;
    cd_ready[1] = r1;
  endtask

  // One clock: check every combinational output against the model, then advance.
  task automatic cycle();
    bit             elig [2];
    int             win, didx, k;
    bit             mv, afire, dfire;
    logic [SRC_W:0] aent, dsrc;
    int             old_cnt [2];
    for (int n = 0; n < 2; n++) elig[n] = ca_valid[n] && (exp_cnt[n] < MAX_OUT);
    if (locked) win = owner;
    else if (elig[0] && elig[1]) win = pref;
    else win = elig[1] ? 1 : 0;
    mv = locked ? elig[owner] : (elig[0] || elig[1]);
    didx = int'(md_source[SRC_W]);
    #1;
    chk("m_a_valid", m_a_valid, mv);
    if (mv) begin
      chk("m_a_source", m_a_source, {win[0], ca_source[win]});
      chk("m_a_address", m_a_address, ca_address[win]);
      chk("m_a_payload", {m_a_opcode, m_a_param, m_a_size, m_a_mask, m_a_data},
          {ca_opcode[win], ca_param[win], ca_size[win], ca_mask[win], ca_data[win]});
    end
    chk("c0_a_ready", c0_a_ready, mv && ma_ready && win == 0);
    chk("c1_a_ready", c1_a_ready, mv && ma_ready && win == 1);
    chk("c0_d_valid", c0_d_valid, md_valid && didx == 0);
    chk("c1_d_valid", c1_d_valid, md_valid && didx == 1);
    chk("m_d_ready", m_d_ready, cd_ready[didx]);
    chk("c0_d_fields", {c0_d_opcode, c0_d_param, c0_d_size, c0_d_source, c0_d_sink,
        c0_d_denied, c0_d_corrupt, c0_d_data}, {md_opcode, md_param, md_size,
        md_source[SRC_W-1:0], md_sink, md_denied, md_corrupt, md_data});
    chk("c1_d_fields", {c1_d_opcode, c1_d_param, c1_d_size, c1_d_source, c1_d_sink,
        c1_d_denied, c1_d_corrupt, c1_d_data}, {md_opcode, md_param, md_size,
        md_source[SRC_W-1:0], md_sink, md_denied, md_corrupt, md_data});
    chk("err_flag", err_unexpected_d, exp_err);
    afire = mv && ma_ready;
    aent  = {win[0], ca_source[win]};
    dfire = md_valid && cd_ready[didx];
    dsrc  = md_source;
    for (int n = 0; n < 2; n++) fired[n] = afire && (win == n);
    @(posedge clock);
    old_cnt = exp_cnt;
    if (afire) begin
      exp_cnt[win]++;
      pref = 1 - win;
      mgr_q.push_back(aent);
    end
    locked = mv && !ma_ready;
    if (locked) owner = win;
    if (dfire) begin
      if (old_cnt[didx] == 0) exp_err = 1'b1;
      else exp_cnt[didx]--;
      k = -1;
      for (int i = 0; i < mgr_q.size(); i++) if (k < 0 && mgr_q[i] == dsrc) k = i;
      if (k >= 0) mgr_q.delete(k);
    end
    #1;
  endtask

  task automatic enter_reset();
    reset_n = 1'b0;
    for (int n = 0; n < 2; n++) req(n, 1'b0, '0);
    ma_ready = 1'b1;
    dresp(1'b0, '0, 1'b1, 1'b1);
    exp_cnt = '{0, 0};
    pref = 0; locked = 1'b0; owner = 0; exp_err = 1'b0;
    mgr_q.delete();
    #1;
    chk("rst_m_a_valid", m_a_valid, 1'b0);
    chk("rst_c0_a_ready", c0_a_ready, 1'b0);
    chk("rst_c1_a_ready", c1_a_ready, 1'b0);
    chk("rst_c0_d_valid", c0_d_valid, 1'b0);
    chk("rst_c1_d_valid", c1_d_valid, 1'b0);
    chk("rst_err", err_unexpected_d, 1'b0);
    @(posedge clock);
    #1;
    chk("rst_hold_err", err_unexpected_d, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 2; n++) ca_valid[n] = 1'b0;
    for (int k = 0; k < 40 && mgr_q.size() > 0; k++) begin
      dresp(1'b1, mgr_q[0], 1'b1, 1'b1);
      cycle();
    end
    dresp(1'b0, '0, 1'b1, 1'b1);
    chk("drain_empty", mgr_q.size(), 0);
  endtask

  initial begin
    logic [ADDR_W-1:0] lk_addr;
    bit                pend [2];
    #6;
    enter_reset();

    // Alternating grant with both clients requesting
    req(0, 1'b1, 2'd1);
    req(1, 1'b1, 2'd2);
    ma_ready = 1'b1;
    dresp(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_grant", m_a_source[SRC_W], (i % 2));
      cycle();
    end

    // Simultaneous A and D on client 0 at count 2, then fill it to the limit
    req(1, 1'b0, '0);
    dresp(1'b1, 3'b001, 1'b1, 1'b1);
    cycle();
    dresp(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("simul_fill_c0", c0_a_ready, (i < 2));
      cycle();
    end

    // D routing by the top source bit
    req(0, 1'b0, '0);
    dresp(1'b1, 3'b110, 1'b1, 1'b0);
    #1;
    chk("droute_c1_valid", c1_d_valid, 1'b1);
    chk("droute_c1_source", c1_d_source, 2'b10);
    chk("droute_c0_valid", c0_d_valid, 1'b0);
    chk("droute_ready_lo", m_d_ready, 1'b0);
    cycle();
    dresp(1'b1, 3'b110, 1'b0, 1'b1);
    #1;
    chk("droute_ready_hi", m_d_ready, 1'b1);
    cycle();
    drain();

    // Lock under backpressure
    req(0, 1'b1, 2'd3);
    lk_addr = ca_address[0];
    req(1, 1'b0, '0);
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) req(1, 1'b1, 2'd0);
      if (i == 5) req(0, 1'b1, 2'd1);
      ma_ready = (i >= 4);
      #1;
      if (i <= 4) begin
        chk("lock_addr", m_a_address, lk_addr);
        chk("lock_source", m_a_source, 3'b011);
      end else begin
        chk("lock_then_c1", c1_a_ready, 1'b1);
      end
      cycle();
    end
    drain();

    // Outstanding limit on client 1
    ma_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req(1, 1'b1, SRC_W'(i));
      cycle();
    end
    req(0, 1'b1, 2'd0);
    #1;
    chk("limit_c1_stall", c1_a_ready, 1'b0);
    chk("limit_c0_grant", c0_a_ready, 1'b1);
    cycle();
    req(0, 1'b0, '0);
    dresp(1'b1, 3'b100, 1'b1, 1'b1);
    #1;
    chk("limit_same_cycle", c1_a_ready, 1'b0);
    cycle();
    dresp(1'b0, '0, 1'b1, 1'b1);
    #1;
    chk("limit_reopen", c1_a_ready, 1'b1);
    cycle();
    drain();

    // Unexpected D sets a sticky flag
    dresp(1'b1, 3'b000, 1'b1, 1'b1);
    cycle();
    dresp(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("err_sticky", err_unexpected_d, 1'b1);
      cycle();
    end

    // Reset while client 1 holds the lock and client 0 is at its limit
    for (int i = 0; i < 4; i++) begin
      req(0, 1'b1, SRC_W'(i));
      cycle();
    end
    req(1, 1'b1, 2'd1);
    ma_ready = 1'b0;
    #1;
    chk("pre_rst_owner", m_a_source[SRC_W], 1'b1);
    cycle();
    enter_reset();
    req(0, 1'b1, 2'd2);
    req(1, 1'b1, 2'd3);
    ma_ready = 1'b1;
    #1;
    chk("post_rst_c0_grant", c0_a_ready, 1'b1);
    cycle();

    // Random traffic with a responding manager
    pend = '{1'b1, 1'b1};
    for (int t = 0; t < 400; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n]) begin
          if ($urandom_range(1, 0) == 1) begin
            req(n, 1'b1, SRC_W'($urandom));
            pend[n] = 1'b1;
          end else begin
            ca_valid[n] = 1'b0;
          end
        end
      end
      ma_ready = ($urandom_range(3, 0) != 0);
      if (mgr_q.size() > 0 && $urandom_range(1, 0) == 1)
        dresp(1'b1, mgr_q[$urandom_range(mgr_q.size() - 1, 0)],
              1'($urandom), 1'($urandom));
      else
        dresp(1'b0, SRC_W'($urandom), 1'($urandom), 1'($urandom));
      cycle();
      for (int n = 0; n < 2; n++) if (fired[n]) pend[n] = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
